// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle ARM control unit.
//   - state_t and the FSM state constants
//   - ALU control encodings (3-bit superset; the 2-bit mode uses the low bits)
//   - data-processing cmd, opcode and condition-code constants
//   - decode_cmd(): maps a data-processing cmd onto ALU operation and attributes
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  typedef struct packed {
    logic       supported;   // cmd is implemented in this ALU mode
    logic       arith;       // ADD/SUB family: C and V are meaningful
    logic       compare;     // CMP/CMN/TST: result only feeds the flags
    logic [2:0] alu;         // ALU operation (ADD when unsupported)
  } alu_dec_t;

  function automatic alu_dec_t decode_cmd(input logic [3:0] cmd, input logic eor_ok);
    alu_dec_t d;
    d = '{supported: 1'b1, arith: 1'b0, compare: 1'b0, alu: ALU_ADD};
    case (cmd)
      CMD_ADD: begin d.alu = ALU_ADD; d.arith = 1'b1; end
      CMD_SUB: begin d.alu = ALU_SUB; d.arith = 1'b1; end
      CMD_AND: d.alu = ALU_AND;
      CMD_ORR: d.alu = ALU_ORR;
      CMD_CMP: begin d.alu = ALU_SUB; d.arith = 1'b1; d.compare = 1'b1; end
      CMD_CMN: begin d.alu = ALU_ADD; d.arith = 1'b1; d.compare = 1'b1; end
      CMD_TST: begin d.alu = ALU_AND; d.compare = 1'b1; end
      CMD_EOR: begin
        if (eor_ok) d.alu = ALU_EOR;
        else        d.supported = 1'b0;
      end
      default: d.supported = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_condcheck.sv
// Combinational ARM condition evaluation.
// Ports:
//   cond    in  4  instruction condition field
//   flags   in  4  current NZCV register (N = bit 3)
//   cond_ex out 1  1 when the instruction should execute
// Condition 1111 is treated like AL.
module mc_condcheck
  import mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  always_comb begin
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM datapath: a Moore FSM that sequences
// FETCH..writeback, decodes the ALU operation, and holds the NZCV flags and
// the registered condition result used by every state after DECODE.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Instr[19:0]           IR[31:12]: cond, op, funct, Rn, Rd
//   ALUFlags[3:0]         NZCV from the ALU (valid in EXECUTER/EXECUTEI)
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   enables / address select
//   ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0]          datapath muxes
//   ImmSrc[1:0], RegSrc[1:0]                       decoded from op
//   ALUControl[ALUCTRL_W-1:0]                      ALU operation
//   dbg_state[3:0], dbg_flags[3:0]                 FSM state and NZCV for observation
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int ALUCTRL_W  = 2,
  parameter bit EN_NOWRITE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           dbg_state,
  output logic [3:0]           dbg_flags
);

  localparam bit EOR_OK = (ALUCTRL_W >= 3);

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_r_q, cond_ex_r_d;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       funct5, s_bit, u_bit, l_bit;
  logic       cond_ex;
  alu_dec_t   dec;

  // Moore outputs before condition gating
  logic       next_pc, branch, reg_w, mem_w, ir_write;
  logic       adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b, flag_w;
  logic [2:0] alu_sel;

  logic       is_dp, no_write, reg_w_eff, pcs;
  logic       unused_ok;

  assign cond   = Instr[19:16];
  assign op     = Instr[15:14];
  assign funct5 = Instr[13];
  assign u_bit  = Instr[11];       // funct[3]
  assign cmd    = Instr[12:9];     // funct[4:1]
  assign s_bit  = Instr[8];        // funct[0], also the L bit for memory ops
  assign l_bit  = Instr[8];
  assign rd     = Instr[3:0];
  assign unused_ok = ^Instr[7:4];  // Rn is a datapath concern

  mc_condcheck u_condcheck (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  assign dec   = decode_cmd(cmd, EOR_OK);
  assign is_dp = (op == OP_DP);

  // Compare-class suppression and unsupported-cmd suppression only make
  // sense for data-processing instructions; memory ops reuse funct bits.
  assign no_write = EN_NOWRITE && is_dp && dec.compare;

  always_comb begin
    state_d    = state_q;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_sel    = ALU_ADD;
    flag_w     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct5 ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;   // undefined opcode retires silently
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        alu_sel   = u_bit ? ALU_ADD : ALU_SUB;
        state_d   = l_bit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        alu_src_b = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        alu_sel   = dec.alu;
        // NZ follow every flag-setting op; CV only arithmetic ones.
        flag_w    = {s_bit & dec.supported, s_bit & dec.supported & dec.arith};
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Flags and CondExR: CondExR is captured once per instruction, so a
  // flag update in EXECUTE cannot change the same instruction's writeback.
  always_comb begin
    flags_d     = flags_q;
    cond_ex_r_d = cond_ex_r_q;
    if (state_q == S_DECODE) cond_ex_r_d = cond_ex;
    if (cond_ex_r_q) begin
      if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      flags_q     <= 4'b0000;
      cond_ex_r_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      cond_ex_r_q <= cond_ex_r_d;
    end
  end

  assign reg_w_eff = reg_w & (~is_dp | dec.supported);
  assign pcs       = branch | (reg_w_eff & (rd == 4'hF));

  // While reset is high no write may leak out and the muxes show FETCH.
  always_comb begin
    PCWrite    = ~reset & (next_pc | (pcs & cond_ex_r_q & ~no_write));
    MemWrite   = ~reset & mem_w & cond_ex_r_q;
    IRWrite    = ~reset & ir_write;
    RegWrite   = ~reset & reg_w_eff & cond_ex_r_q & ~no_write;
    AdrSrc     = reset ? 1'b0    : adr_src;
    ResultSrc  = reset ? 2'b10   : result_src;
    ALUSrcA    = reset ? 1'b1    : alu_src_a;
    ALUSrcB    = reset ? 2'b10   : alu_src_b;
    ALUControl = ALUCTRL_W'(reset ? ALU_ADD : alu_sel);
  end

  assign ImmSrc    = op;
  assign RegSrc    = {op == 2'b01, op == 2'b10};
  assign dbg_state = state_q;
  assign dbg_flags = flags_q;

endmodule
